// File: rtl/timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : timer_ctrl
//  Purpose  : Stopwatch control. Synchronizes and debounces the two
//             active-low board keys, turns accepted presses into one-cycle
//             events and sequences the stopwatch through IDLE / RUN / PAUSE /
//             LAP. Produces the count-enable tick, the counter clear strobe
//             and the display lap-freeze controls.
//
//  Ports    : clk       in   system clock, rising edge
//             rst_n     in   synchronous active-low reset
//             KEY0      in   start/stop key, asynchronous, 0 = pressed
//             KEY1      in   lap/clear key, asynchronous, 0 = pressed
//             tick      out  one-cycle count-enable pulse
//             cnt_clr   out  one-cycle timer counter clear
//             lap_stb   out  one-cycle display capture pulse
//             lap_hold  out  display shows latched lap value while high
//             state     out  0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
//
//  Revision : 1.0  initial release
// ============================================================================
module timer_ctrl #(
    parameter int DEBOUNCE_CYC = 250000,   // stable cycles before a level is accepted
    parameter int TICK_DIV     = 500000    // clock cycles per count tick, >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       KEY0,
    input  logic       KEY1,
    output logic       tick,
    output logic       cnt_clr,
    output logic       lap_stb,
    output logic       lap_hold,
    output logic [1:0] state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int c_PS_W = $clog2(TICK_DIV);

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Key conditioning: 2-FF synchronizer, debouncer, press-edge detector.
    // Bit 0 is KEY0 (start/stop), bit 1 is KEY1 (lap/clear).
    // ------------------------------------------------------------------------
    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {KEY1, KEY0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic              r_sync1;
            logic              r_sync2;
            logic              r_acc;      // accepted (debounced) level
            logic              r_acc_d;    // accepted level one cycle ago
            logic              r_press;    // registered press event
            logic [c_DB_W-1:0] r_cnt;      // consecutive-difference counter

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_acc   <= 1'b1;
                    r_acc_d <= 1'b1;
                    r_press <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_key_raw[gi];
                    r_sync2 <= r_sync1;
                    r_acc_d <= r_acc;

                    // Only the accepted 1->0 edge is an event; releases are
                    // tracked by the debouncer but never reported.
                    r_press <= r_acc_d & ~r_acc;

                    // The counter measures how long the synchronized input
                    // has disagreed with the accepted level. Any agreement
                    // restarts the measurement, so a short glitch is lost.
                    if (r_sync2 == r_acc) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_acc <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    // KEY0 has priority: a simultaneous KEY1 event is dropped.
    logic w_ev_start;
    logic w_ev_lap;

    assign w_ev_start = w_press[0];
    assign w_ev_lap   = w_press[1] & ~w_press[0];

    // ------------------------------------------------------------------------
    // Prescaler helpers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic              r_tick;
    logic              r_clr;
    logic              r_lap_stb;
    logic              r_lap_hold;
    logic [c_PS_W-1:0] r_presc;

    logic              w_presc_wrap;
    logic [c_PS_W-1:0] w_presc_nxt;

    assign w_presc_wrap = (r_presc == c_PS_LAST);
    assign w_presc_nxt  = w_presc_wrap ? '0 : r_presc + 1'b1;

    // ------------------------------------------------------------------------
    // Control FSM with prescaler and registered strobes.
    //
    // The prescaler advances only on edges where the stopwatch is running
    // and stays running. On the RUN/LAP -> PAUSE edge it is frozen, so the
    // paused value is exactly the phase that a later resume continues from,
    // and a wrap can never put a tick into the first PAUSE cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick     <= 1'b0;
            r_clr      <= 1'b0;
            r_lap_stb  <= 1'b0;
            r_lap_hold <= 1'b0;
            r_presc    <= '0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            r_tick    <= 1'b0;
            r_clr     <= 1'b0;
            r_lap_stb <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // KEY1 does nothing here; a clear is only meaningful
                    // from PAUSE.
                    if (w_ev_start) begin
                        r_state <= S_RUN;
                        r_presc <= '0;
                    end
                end

                S_RUN: begin
                    if (w_ev_start) begin
                        r_state <= S_PAUSE;
                    end else begin
                        if (w_ev_lap) begin
                            r_state    <= S_LAP;
                            r_lap_stb  <= 1'b1;
                            r_lap_hold <= 1'b1;
                        end
                        r_presc <= w_presc_nxt;
                        r_tick  <= w_presc_wrap;
                    end
                end

                S_LAP: begin
                    // Counting continues underneath the frozen display.
                    if (w_ev_start) begin
                        r_state    <= S_PAUSE;
                        r_lap_hold <= 1'b0;
                    end else begin
                        if (w_ev_lap) begin
                            r_state    <= S_RUN;
                            r_lap_hold <= 1'b0;
                        end
                        r_presc <= w_presc_nxt;
                        r_tick  <= w_presc_wrap;
                    end
                end

                S_PAUSE: begin
                    if (w_ev_start) begin
                        // Resume keeps the prescaler phase.
                        r_state <= S_RUN;
                    end else if (w_ev_lap) begin
                        r_state <= S_IDLE;
                        r_clr   <= 1'b1;
                        r_presc <= '0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tick     = r_tick;
    assign cnt_clr  = r_clr;
    assign lap_stb  = r_lap_stb;
    assign lap_hold = r_lap_hold;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_timer_ctrl
//  Purpose  : Self-checking bench for timer_ctrl with DEBOUNCE_CYC=4,
//             TICK_DIV=10. A behavioural model steps on every rising edge
//             and the outputs are compared on every falling edge; directed
//             scenarios add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_ctrl;

    localparam int DC = 4;
    localparam int TD = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       KEY0  = 1'b1;
    logic       KEY1  = 1'b1;
    logic       tick;
    logic       cnt_clr;
    logic       lap_stb;
    logic       lap_hold;
    logic [1:0] state;

    timer_ctrl #(
        .DEBOUNCE_CYC (DC),
        .TICK_DIV     (TD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .KEY0     (KEY0),
        .KEY1     (KEY1),
        .tick     (tick),
        .cnt_clr  (cnt_clr),
        .lap_stb  (lap_stb),
        .lap_hold (lap_hold),
        .state    (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;       // number of rising edges so far

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    bit m_valid = 1'b0;
    int m_state = 0;
    bit m_tick, m_clr, m_lap, m_hold;
    int m_run   = 0;        // running edges since the stopwatch was started
    bit m_p1 [2];           // pin delayed by one edge
    bit m_p2 [2];           // pin delayed by two edges
    bit m_win [2][DC];      // last DC synchronized samples, [0] newest
    bit m_acc [2];          // debounced level
    bit m_fell [2];         // debounced level fell on the last edge
    bit m_ev [2];           // press event visible to the FSM

    // tick bookkeeping for the literal spacing check
    int tick_seen  = 0;
    int last_tick  = 0;
    bit spacing_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit e0, e1, run_old, run_new, all_diff, seen;
        int nx;
        if (!rst_n) begin
            m_valid = 1'b1;
            m_state = 0;
            m_tick = 0; m_clr = 0; m_lap = 0; m_hold = 0;
            m_run = 0;
            for (int i = 0; i < 2; i++) begin
                m_p1[i] = 1; m_p2[i] = 1; m_acc[i] = 1;
                m_fell[i] = 0; m_ev[i] = 0;
                for (int j = 0; j < DC; j++) m_win[i][j] = 1;
            end
            return;
        end
        // Transition table driven by the events visible before this edge.
        e0 = m_ev[0];
        e1 = m_ev[1] && !m_ev[0];
        nx = m_state;
        m_clr = 0; m_lap = 0; m_tick = 0;
        case (m_state)
            0: if (e0) nx = 1;
            1: if (e0) nx = 2;
               else if (e1) begin nx = 3; m_lap = 1; m_hold = 1; end
            2: if (e0) nx = 1;
               else if (e1) begin nx = 0; m_clr = 1; end
            default: if (e0) begin nx = 2; m_hold = 0; end
               else if (e1) begin nx = 1; m_hold = 0; end
        endcase
        run_old = (m_state == 1) || (m_state == 3);
        run_new = (nx == 1) || (nx == 3);
        if (m_state == 0 && nx == 1) m_run = 0;
        else if (m_clr) m_run = 0;
        else if (run_old && run_new) begin
            m_run++;
            m_tick = (m_run % TD == 0);
        end
        m_state = nx;
        // Keys: a level is accepted once DC consecutive synchronized samples
        // all disagree with the current accepted level.
        for (int i = 0; i < 2; i++) begin
            seen = m_p2[i];
            for (int j = DC - 1; j > 0; j--) m_win[i][j] = m_win[i][j-1];
            m_win[i][0] = seen;
            all_diff = 1;
            for (int j = 0; j < DC; j++) if (m_win[i][j] == m_acc[i]) all_diff = 0;
            m_ev[i]   = m_fell[i];
            m_fell[i] = all_diff && (seen == 0);
            if (all_diff) m_acc[i] = seen;
            m_p2[i] = m_p1[i];
            m_p1[i] = (i == 0) ? KEY0 : KEY1;
        end
    endtask

    // One clock: model on the rising edge, compare on the falling edge.
    task automatic nxt();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        if (m_valid)
            chk("outputs{state,tick,clr,stb,hold}",
                int'({state, tick, cnt_clr, lap_stb, lap_hold}),
                int'({m_state[1:0], m_tick, m_clr, m_lap, m_hold}));
        if (tick) begin
            tick_seen++;
            if (spacing_en) chk("tick_spacing", cyc - last_tick, TD);
            last_tick = cyc;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) nxt();
    endtask

    task automatic setkey(input int key, input logic v);
        if (key == 0 || key == 2) KEY0 = v;
        if (key == 1 || key == 2) KEY1 = v;
    endtask

    // Press and wait (bounded) for the target state; checks fixed latency.
    task automatic press_until(input int key, input int target,
                               output int n0, output int at);
        setkey(key, 1'b0);
        n0 = cyc;
        at = -1;
        for (int k = 0; k < 20; k++) begin
            nxt();
            if (int'(state) == target) begin
                at = cyc;
                break;
            end
        end
        chk("press_latency", at - (n0 + 1), 7);
    endtask

    // Hold for at least 10 low samples, release, let the release settle.
    task automatic release_after(input int key, input int n0);
        while (cyc - n0 < 10) nxt();
        setkey(key, 1'b1);
        cycles(12);
    endtask

    int n0, t_run, t_lap, t_p, t_r, t_c, t_b, n_bad;
    int tq[$];

    initial begin
        // ---------------- reset ----------------
        cycles(3);
        chk("rst_state",    int'(state),    0);
        chk("rst_tick",     int'(tick),     0);
        chk("rst_cnt_clr",  int'(cnt_clr),  0);
        chk("rst_lap_stb",  int'(lap_stb),  0);
        chk("rst_lap_hold", int'(lap_hold), 0);
        rst_n = 1'b1;
        n_bad = 0;
        repeat (100) begin
            nxt();
            if (tick || cnt_clr || lap_stb || lap_hold || state != 2'd0) n_bad++;
        end
        chk("idle_quiet", n_bad, 0);

        // ---------------- glitch: 3 low samples ----------------
        KEY0 = 1'b0;
        cycles(3);
        KEY0 = 1'b1;
        n_bad = 0;
        repeat (30) begin
            nxt();
            if (tick || state != 2'd0) n_bad++;
        end
        chk("glitch_ignored", n_bad, 0);

        // ---------------- start ----------------
        press_until(0, 1, n0, t_run);
        spacing_en = 1'b1;
        last_tick  = t_run;
        for (int k = 0; k < 35; k++) begin
            if (cyc - n0 == 10) KEY0 = 1'b1;
            nxt();
            if (tick) tq.push_back(cyc - t_run);
        end
        chk("start_tick_count", tq.size(), 3);
        if (tq.size() == 3) begin
            chk("start_tick1", tq[0], 10);
            chk("start_tick2", tq[1], 20);
            chk("start_tick3", tq[2], 30);
        end

        // ---------------- lap in / lap out ----------------
        press_until(1, 3, n0, t_lap);
        chk("lap_stb_on",  int'(lap_stb),  1);
        chk("lap_hold_on", int'(lap_hold), 1);
        nxt();
        chk("lap_stb_off",  int'(lap_stb),  0);
        chk("lap_hold_kept", int'(lap_hold), 1);
        release_after(1, n0);
        press_until(1, 1, n0, t_lap);
        chk("unlap_hold", int'(lap_hold), 0);
        chk("unlap_stb",  int'(lap_stb),  0);
        release_after(1, n0);

        // ---------------- pause with prescaler at 6 ----------------
        for (int k = 0; k < 10 && ((cyc - t_run) % TD) != 9; k++) nxt();
        spacing_en = 1'b0;
        press_until(0, 2, n0, t_p);
        chk("pause_presc_model", m_run % TD, 6);
        tick_seen = 0;
        release_after(0, n0);
        while (cyc - t_p < 50) nxt();
        chk("pause_no_tick", tick_seen, 0);
        chk("pause_state", int'(state), 2);

        // ---------------- resume ----------------
        press_until(0, 1, n0, t_r);
        for (int k = 0; k < 20; k++) begin
            nxt();
            if (tick) break;
        end
        chk("resume_first_tick", cyc - t_r, 4);
        release_after(0, n0);

        // ---------------- pause, then clear ----------------
        press_until(0, 2, n0, t_p);
        release_after(0, n0);
        press_until(1, 0, n0, t_c);
        chk("clr_pulse_on", int'(cnt_clr), 1);
        nxt();
        chk("clr_pulse_off", int'(cnt_clr), 0);
        chk("clr_presc", int'(dut.r_presc), 0);
        release_after(1, n0);

        // ---------------- simultaneous presses in IDLE ----------------
        press_until(2, 1, n0, t_b);
        chk("both_no_clr", int'(cnt_clr), 0);
        chk("both_no_stb", int'(lap_stb), 0);
        nxt();
        chk("both_hold", int'(lap_hold), 0);
        release_after(2, n0);

        // ---------------- reset mid-debounce while running ----------------
        KEY0 = 1'b0;
        cycles(4);
        rst_n = 1'b0;
        KEY0  = 1'b1;
        nxt();
        chk("midrst_state", int'(state), 0);
        chk("midrst_outs", int'({tick, cnt_clr, lap_stb, lap_hold}), 0);
        rst_n = 1'b1;
        n_bad = 0;
        repeat (20) begin
            nxt();
            if (tick || cnt_clr || lap_stb || lap_hold || state != 2'd0) n_bad++;
        end
        chk("midrst_quiet", n_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_ctrl.md
# timer_ctrl

Button-driven control FSM for the stopwatch timer datapath. It debounces the two active-low board keys and turns them into single press events. It then sequences the stopwatch through idle/run/pause/lap and produces the count-enable tick, clear and lap-freeze strobes that drive the timer counter and display. It sits between the KEY pins and the timer counter on the 50 MHz board clock.

## Interface
- DEBOUNCE_CYC, 250000: consecutive stable cycles before a key level is accepted (5 ms at 50 MHz).
- TICK_DIV, 500000: clock cycles per count tick (10 ms at 50 MHz); must be ≥ 2.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- KEY0  in  1  start/stop key, asynchronous, active-low (0 = pressed).
- KEY1  in  1  lap/clear key, asynchronous, active-low (0 = pressed).
- tick  out  1  one-cycle count-enable pulse to the timer counter.
- cnt_clr  out  1  one-cycle clear pulse to the timer counter.
- lap_stb  out  1  one-cycle capture pulse: display latches the current count.
- lap_hold  out  1  level: display shows the latched lap value instead of the live count.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP.

## Operation
- Each key passes through a 2-FF synchronizer and then a debouncer.
- The debouncer holds an accepted level, which resets to 1 (released).
  - A counter increments while the synchronized input differs from the accepted level.
  - The counter clears to 0 whenever the two are equal.
  - When the counter reaches DEBOUNCE_CYC-1 and they still differ, the accepted level flips and the counter clears.
- A press event is a registered one-cycle pulse on an accepted 1→0 transition. Releases generate no event.
- KEY0 and KEY1 press events in the same cycle: KEY0 wins and the KEY1 event is discarded.
- FSM transitions, taken on press events:
  - IDLE: KEY0 → RUN, prescaler cleared to 0. KEY1 is ignored.
  - RUN: KEY0 → PAUSE. KEY1 → LAP, with lap_stb pulsed and lap_hold set.
  - LAP: KEY1 → RUN, lap_hold cleared. KEY0 → PAUSE, lap_hold cleared.
  - PAUSE: KEY0 → RUN, prescaler keeps its value. KEY1 → IDLE, with cnt_clr pulsed and prescaler cleared.
- Prescaler behaviour:
  - Width is $clog2(TICK_DIV).
  - It counts 0..TICK_DIV-1 only in RUN or LAP, and holds its value in PAUSE and IDLE.
  - It wraps from TICK_DIV-1 to 0.
  - tick is high for the single cycle after the edge at which the prescaler wraps.
- Counting continues in LAP; only the display is frozen.
- tick is never high while state is IDLE or PAUSE.

## Timing
- Reset values: state=0 (IDLE), tick=0, cnt_clr=0, lap_stb=0, lap_hold=0, prescaler=0, debounce counters=0, accepted levels=1.
- Reset mid-operation: on the next edge with rst_n=0, everything returns to reset values. cnt_clr is not pulsed. An in-progress debounce is discarded.
- Key-to-state latency is fixed and equals DEBOUNCE_CYC+3 edges from the first rising edge that samples the pin low. The state register updates on that edge.
- lap_stb and cnt_clr are registered, go high in the same cycle the new state appears, and last exactly 1 cycle.
- lap_hold changes in the same cycle as state.
- Entry into RUN from IDLE: the first tick comes TICK_DIV cycles after state becomes 1, then every TICK_DIV cycles.
- Resume from PAUSE with prescaler value p: the first tick comes TICK_DIV-p cycles after state becomes 1.
- A key held down produces exactly one event. Another event needs a debounced release and then a new press.
- A glitch shorter than DEBOUNCE_CYC cycles produces no event and no state change.

## Test plan
All scenarios use DEBOUNCE_CYC=4 and TICK_DIV=10.
- Reset: rst_n=0 for 3 cycles with both keys high → state=0 and tick, cnt_clr, lap_stb, lap_hold all 0. They stay 0 for 100 cycles after release.
- Start: KEY0 held low for 10 cycles from IDLE → state=1 exactly 7 edges after the first low sample. tick pulses 10, 20, 30 cycles after entry, each 1 cycle wide.
- Glitch: KEY0 low for 3 cycles and then high, in IDLE → state stays 0 and no tick ever occurs.
- Lap: KEY1 press in RUN → state=3, lap_stb high 1 cycle, lap_hold=1, ticks keep their 10-cycle spacing. A second KEY1 press → state=1, lap_hold=0, no lap_stb.
- Pause/resume: KEY0 press in RUN with prescaler at 6 → state=2, no tick for 50 cycles. KEY0 press again → state=1 and the first tick comes 4 cycles later.
- Clear and priority:
  - KEY1 press in PAUSE → state=0, cnt_clr high 1 cycle, prescaler=0.
  - KEY0 and KEY1 pressed on the same cycle in IDLE → state=1, with no cnt_clr and no lap_stb.
